fifo_ctrl_32x8: RTL and testbench

- Control unit for the 32-word x 8-bit structural RAM FIFO.
- Owns the write and read pointers, and drives the 5-bit RAM write/read address selects that feed the RAM's 5-to-32 word decoders.
- Generates the RAM write and read enables and reports occupancy status to the producer and consumer.
- Contains no datapath storage. Data flows producer -> RAM -> consumer directly; this block sequences it.

---
 rtl/fifo_ctrl_32x8.sv | 151 +++++++++++++++
 tb/tb_fifo_ctrl_32x8.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_32x8.sv
// Pointer/flag controller for a 32x8 RAM FIFO: owns wptr/rptr, drives RAM word selects and enables.
// Optional sticky overflow/underflow flags with err_clr are built when FIFO_CTRL_ERR_FLAGS_EN is defined.
module fifo_ctrl_32x8 #(
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic [1:0]    state_dbg
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  ,
  input  logic          err_clr,
  output logic          overflow,
  output logic          underflow
`endif
);

  // Handshake: a push is taken (ram_we) in any cycle where push=1 and full=0; a pop is taken
  // (ram_re) when pop=1 and empty=0. Read data is qualified by rd_valid exactly one cycle later.

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_e;

  localparam logic [AW:0] AF_L   = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_L   = AE_LEVEL[AW:0];
  localparam logic [AW:0] LAST_L = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE_L  = (AW+1)'(1);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        af_q, af_d;
  logic        ae_q, ae_d;
  logic        rd_valid_q, rd_valid_d;
  state_e      state_q, state_d;
  logic        wr_ok, rd_ok;

  assign wr_ok = push & ~full_q;
  assign rd_ok = pop & ~empty_q;

  // Flags are registered from the next-cycle pointers so they line up with the pointer update.
  always_comb begin
    wptr_d     = wptr_q + {{AW{1'b0}}, wr_ok};
    rptr_d     = rptr_q + {{AW{1'b0}}, rd_ok};
    count_d    = wptr_d - rptr_d;
    empty_d    = (wptr_d == rptr_d);
    full_d     = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
    af_d       = (count_d >= AF_L);
    ae_d       = (count_d <= AE_L);
    rd_valid_d = rd_ok;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY:  if (wr_ok) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (wr_ok && !rd_ok && count_q == LAST_L)     state_d = ST_FULL;
        else if (rd_ok && !wr_ok && count_q == ONE_L) state_d = ST_EMPTY;
      end
      ST_FULL:   if (rd_ok) state_d = ST_ACTIVE;
      default:   state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      rd_valid_q <= 1'b0;
      state_q    <= ST_EMPTY;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      rd_valid_q <= rd_valid_d;
      state_q    <= state_d;
    end
  end

  assign ram_we       = wr_ok;
  assign ram_re       = rd_ok;
  assign ram_waddr    = wptr_q[AW-1:0];
  assign ram_raddr    = rptr_q[AW-1:0];
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign state_dbg    = state_q;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A new illegal request in the same cycle as err_clr keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (push && full_q) ovf_d = 1'b1;
    if (pop && empty_q) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl_32x8.sv
// Randomized and directed bench for fifo_ctrl_32x8 with a queue-based reference model and address scoreboard.
module tb_fifo_ctrl_32x8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push, pop;
  logic       ram_we, ram_re, rd_valid;
  logic [4:0] ram_waddr, ram_raddr;
  logic       full, empty, almost_full, almost_empty;
  logic [5:0] count;
  logic [1:0] state_dbg;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic       err_clr;
  logic       overflow, underflow;
  bit         m_ovf, m_unf;
`endif

  fifo_ctrl_32x8 dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_re(ram_re), .ram_raddr(ram_raddr),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .state_dbg(state_dbg)
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    , .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         mq[$];
  logic [4:0] exp_wr_q[$];
  logic [4:0] exp_rd_q[$];
  int         mw = 0;
  bit         exp_rv = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int n;
    n = mq.size();
    chk("count", int'(count), n);
    chk("full", int'(full), int'(n == 32));
    chk("empty", int'(empty), int'(n == 0));
    chk("almost_full", int'(almost_full), int'(n >= 28));
    chk("almost_empty", int'(almost_empty), int'(n <= 4));
    chk("rd_valid", int'(rd_valid), int'(exp_rv));
    chk("state", int'(state_dbg), (n == 0) ? 0 : ((n == 32) ? 2 : 1));
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
`endif
  endtask

  // One cycle: check state left by the previous edge, then apply new requests and update the model.
  task automatic step(input bit p, input bit q);
    bit wr_acc, rd_acc;
    @(posedge clk);
    #1;
    check_status();
    push = p;
    pop  = q;
    wr_acc = p && (mq.size() < 32);
    rd_acc = q && (mq.size() > 0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    if (p && mq.size() == 32) m_ovf = 1'b1;
    if (q && mq.size() == 0)  m_unf = 1'b1;
`endif
    if (rd_acc) exp_rd_q.push_back(5'(mq.pop_front()));
    if (wr_acc) begin
      exp_wr_q.push_back(5'(mw));
      mq.push_back(mw);
      mw = (mw + 1) % 32;
    end
    exp_rv = rd_acc;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_wr_q.delete();
    exp_rd_q.delete();
    mw     = 0;
    exp_rv = 1'b0;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    m_ovf = 1'b0;
    m_unf = 1'b0;
`endif
  endtask

  // Monitor: every RAM access presented by the DUT must match the next expected address.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ram_we === 1'b1) begin
        if (exp_wr_q.size() == 0) chk("unexpected_ram_we", 1, 0);
        else chk("ram_waddr", int'(ram_waddr), int'(exp_wr_q.pop_front()));
      end
      if (ram_re === 1'b1) begin
        if (exp_rd_q.size() == 0) chk("unexpected_ram_re", 1, 0);
        else chk("ram_raddr", int'(ram_raddr), int'(exp_rd_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    push  = 1'b0;
    pop   = 1'b0;
    rst_n = 1'b0;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("waddr_rst", int'(ram_waddr), 0);
    chk("raddr_rst", int'(ram_raddr), 0);

    // Fill plus one rejected push, drain plus one rejected pop.
    repeat (33) step(1'b1, 1'b0);
    repeat (33) step(1'b0, 1'b1);

    // Wrap: write addresses continue 20..31 then 0..7.
    repeat (20) step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b0);

    // Simultaneous push/pop at full, at empty, and mid-range.
    while (mq.size() < 32) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    while (mq.size() > 0) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    while (mq.size() < 10) step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b1);

    // Random traffic with a drifting bias so both boundaries get visited.
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = ((i / 100) % 2 == 0) ? 70 : 30;
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias));
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    // err_clr clears the sticky flags when no new illegal request arrives.
    step(1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_status();
    err_clr = 1'b1;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    exp_rv  = 1'b0;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check_status();
`endif

    // Asynchronous reset between edges while data is outstanding and rd_valid is high.
    while (mq.size() < 32) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    check_status();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_almost_empty", int'(almost_empty), 1);
    chk("arst_almost_full", int'(almost_full), 0);
    chk("arst_rd_valid", int'(rd_valid), 0);
    chk("arst_waddr", int'(ram_waddr), 0);
    chk("arst_raddr", int'(ram_raddr), 0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    chk("arst_overflow", int'(overflow), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk);
    chk("pending_writes", exp_wr_q.size(), 0);
    chk("pending_reads", exp_rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
